// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types and encodings for the ALU execution unit: the decoded
// operation enum, the one-hot func codes, the ALUOp encodings coming from
// the main control unit, and the execution FSM state enum.
package alu_pkg;

  typedef enum logic [2:0] {
    NOTHING = 3'd0,
    ADD     = 3'd1,
    SUB     = 3'd2,
    AND     = 3'd3,
    OR      = 3'd4,
    SLT     = 3'd5,
    MUL     = 3'd6
  } alu_op_e;

  // One-hot func field codes
  localparam logic [5:0] ADD_FUNC = 6'b000001;
  localparam logic [5:0] SUB_FUNC = 6'b000010;
  localparam logic [5:0] AND_FUNC = 6'b000100;
  localparam logic [5:0] OR_FUNC  = 6'b001000;
  localparam logic [5:0] SLT_FUNC = 6'b010000;
  localparam logic [5:0] MUL_FUNC = 6'b100000;

  // ALUOp encodings from the main control unit
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_SLT  = 2'b10;
  localparam logic [1:0] ALUOP_FUNC = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// alu_decode
// Purely combinational operation decode. Turns the ALUOp field and the
// one-hot func field into a decoded operation and an illegal flag.
// Ports:
//   alu_op_i   in   2  ALUOp from main control
//   func_i     in   6  one-hot func field
//   op_o       out  3  decoded operation (alu_op_e)
//   illegal_o  out  1  unlisted func, or mul while multiply is disabled
module alu_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0] alu_op_i,
  input  logic [5:0] func_i,
  output alu_op_e    op_o,
  output logic       illegal_o
);

  // An illegal code decodes to NOTHING so the datapath yields a zero result.
  always_comb begin
    op_o      = NOTHING;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: op_o = ADD;
      ALUOP_SUB: op_o = SUB;
      ALUOP_SLT: op_o = SLT;
      default: begin
        case (func_i)
          ADD_FUNC: op_o = ADD;
          SUB_FUNC: op_o = SUB;
          AND_FUNC: op_o = AND;
          OR_FUNC:  op_o = OR;
          SLT_FUNC: op_o = SLT;
          MUL_FUNC: begin
            if (MUL_EN) op_o = MUL;
            else        illegal_o = 1'b1;
          end
          default:  illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Handshaked ALU execution stage between decode and writeback. Single-cycle
// operations register their result one cycle after accept; MUL runs an
// iterative shift-and-add over WIDTH cycles. WIDTH must be at least 4.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands and opcode valid
//   in_ready   out  1      unit accepts this cycle
//   alu_op     in   2      ALUOp (00 add, 01 sub, 10 slt, 11 decode func)
//   func       in   6      one-hot func field
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  result
//   zero       out  1      result == 0
//   illegal    out  1      illegal operation was accepted
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             outValid_q, outValid_d;

  alu_op_e          decOp;
  logic             decIllegal;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] accStep;
  logic             accept;

  alu_decode #(
    .MUL_EN (MUL_EN != 0)
  ) u_decode (
    .alu_op_i  (alu_op),
    .func_i    (func),
    .op_o      (decOp),
    .illegal_o (decIllegal)
  );

  // A new op may enter only when idle and the output slot is free or
  // being drained this very cycle.
  assign in_ready  = (state_q == IDLE) && (!outValid_q || out_ready);
  assign accept    = in_valid && in_ready;

  assign out_valid = outValid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Single-cycle datapath; NOTHING (illegal) and MUL fall through to zero.
  always_comb begin
    aluResult = '0;
    case (decOp)
      ADD:     aluResult = a + b;
      SUB:     aluResult = a - b;
      AND:     aluResult = a & b;
      OR:      aluResult = a | b;
      SLT:     aluResult = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: aluResult = '0;
    endcase
  end

  // One shift-and-add step of the multiplier.
  assign accStep = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state logic for the FSM, multiplier datapath and output register.
  // The drain clear comes first so that a same-cycle accept or MUL
  // completion overrides it and keeps out_valid high.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    result_d   = result_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;
    outValid_d = outValid_q;

    if (outValid_q && out_ready) outValid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (decOp == MUL) begin
            state_d  = MUL_RUN;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
          end else begin
            result_d   = aluResult;
            zero_d     = (aluResult == '0);
            illegal_d  = decIllegal;
            outValid_d = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        acc_d    = accStep;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        // Last iteration: the product is complete including this step.
        if (count_q == CW'(1)) begin
          state_d    = IDLE;
          result_d   = accStep;
          zero_d     = (accStep == '0);
          illegal_d  = 1'b0;
          outValid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset discards any partial
  // product and any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
      outValid_q <= outValid_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit. Expected results are pushed to a
// scoreboard queue when an op is accepted and popped when the DUT hands a
// result over. A second instance with MUL_EN=0 covers the disabled multiply.
module tb_alu_exec_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, zero, illegal;
  logic [W-1:0] result;

  logic         in_valid2;
  logic         out_ready2;
  logic         in_ready2, out_valid2, zero2, illegal2;
  logic [W-1:0] result2;

  exp_t sbQueue[$];
  exp_t popped;
  int   testCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  alu_exec_unit #(.WIDTH(W), .MUL_EN(0)) dutNoMul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .alu_op    (alu_op),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .result    (result2),
    .zero      (zero2),
    .illegal   (illegal2)
  );

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference behaviour of one operation.
  function automatic exp_t modelAlu(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [W-1:0] x, input logic [W-1:0] y,
                                    input bit mulEn);
    exp_t e;
    logic [2*W-1:0] prod;
    e.res = '0;
    e.ill = 1'b0;
    case (op)
      2'b00: e.res = x + y;
      2'b01: e.res = x - y;
      2'b10: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: begin
        case (fn)
          6'b000001: e.res = x + y;
          6'b000010: e.res = x - y;
          6'b000100: e.res = x & y;
          6'b001000: e.res = x | y;
          6'b010000: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
          6'b100000: begin
            if (mulEn) begin
              prod  = {{W{1'b0}}, x} * {{W{1'b0}}, y};
              e.res = prod[W-1:0];
            end else begin
              e.ill = 1'b1;
            end
          end
          default: e.ill = 1'b1;
        endcase
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Scoreboard side: every output handshake pops and compares one entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_underflow", 64'd1, 64'd0);
      end else begin
        popped = sbQueue.pop_front();
        checkOutput("sb_result", result, popped.res);
        checkOutput("sb_zero", zero, popped.z);
        checkOutput("sb_illegal", illegal, popped.ill);
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge. Holds the op until it is accepted,
  // pushes its expected result and returns just after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                               input logic [W-1:0] x, input logic [W-1:0] y,
                               output int waits);
    alu_op   = op;
    func     = fn;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      sbQueue.push_back(modelAlu(op, fn, x, y, 1'b1));
      stepCycle();
      in_valid = 1'b0;
    end
  endtask

  // Counts cycles from the accept edge (inclusive) to the edge that raises
  // out_valid, and records whether in_ready rose while waiting.
  task automatic waitResult(output int cycles, output bit readySeen);
    cycles    = 1;
    readySeen = in_ready && !out_valid;
    while (!out_valid && cycles < 200) begin
      stepCycle();
      cycles++;
      if (in_ready && !out_valid) readySeen = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int  waits, lat;
    bit  rdy, sawValid;
    logic [1:0]   rop;
    logic [5:0]   rfn;
    logic [W-1:0] ra, rb;
    logic [5:0]   funcTab [5];

    funcTab[0] = 6'b000001;
    funcTab[1] = 6'b000010;
    funcTab[2] = 6'b000100;
    funcTab[3] = 6'b001000;
    funcTab[4] = 6'b010000;

    // Reset held with a pending request, which must be ignored.
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_valid2  = 1'b0;
    out_ready  = 1'b1;
    out_ready2 = 1'b1;
    alu_op     = 2'b00;
    func       = 6'b000001;
    a          = 5;
    b          = 7;
    repeat (3) stepCycle();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    stepCycle();

    // First accept: add with one cycle of latency.
    applyStimulus(2'b00, 6'b000000, 32'd5, 32'd7, waits);
    waitResult(lat, rdy);
    checkOutput("add_latency", lat, 1);
    checkOutput("add_result", result, 12);
    checkOutput("add_zero", zero, 0);

    // Func-decoded subtract giving zero.
    applyStimulus(2'b11, 6'b000010, 32'd3, 32'd3, waits);
    waitResult(lat, rdy);
    checkOutput("sub_result", result, 0);
    checkOutput("sub_zero", zero, 1);

    // Signed set-less-than in both directions.
    applyStimulus(2'b10, 6'b000000, 32'hFFFF_FFFF, 32'd1, waits);
    waitResult(lat, rdy);
    checkOutput("slt_neg_lt_pos", result, 1);
    applyStimulus(2'b10, 6'b000000, 32'd1, 32'hFFFF_FFFF, waits);
    waitResult(lat, rdy);
    checkOutput("slt_pos_lt_neg", result, 0);

    // Iterative multiply: latency and blocked input.
    applyStimulus(2'b11, 6'b100000, 32'h0001_0003, 32'h0000_0005, waits);
    waitResult(lat, rdy);
    checkOutput("mul_latency", lat, W + 1);
    checkOutput("mul_in_ready_low", rdy, 0);
    checkOutput("mul_result", result, 32'h0005_000F);
    stepCycle();

    // Backpressure: result held, input blocked.
    out_ready = 1'b0;
    applyStimulus(2'b11, 6'b000100, 32'h0000_F0F0, 32'h0000_FF00, waits);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_result", result, 32'h0000_F000);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    stepCycle();
    // Drain and accept in the same cycle.
    out_ready = 1'b1;
    applyStimulus(2'b11, 6'b001000, 32'd1, 32'd2, waits);
    checkOutput("swap_out_valid", out_valid, 1);
    checkOutput("swap_result", result, 3);

    // Illegal func code.
    applyStimulus(2'b11, 6'b000011, 32'h1234_5678, 32'h9ABC_DEF0, waits);
    waitResult(lat, rdy);
    checkOutput("illegal_flag", illegal, 1);
    checkOutput("illegal_result", result, 0);
    checkOutput("illegal_zero", zero, 1);

    // Multiply on the instance with multiply disabled.
    alu_op    = 2'b11;
    func      = 6'b100000;
    a         = 32'd3;
    b         = 32'd4;
    in_valid2 = 1'b1;
    stepCycle();
    in_valid2 = 1'b0;
    checkOutput("nomul_out_valid", out_valid2, 1);
    checkOutput("nomul_illegal", illegal2, 1);
    checkOutput("nomul_result", result2, 0);

    // Back-to-back single-cycle ops at full rate, checked by the scoreboard.
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = funcTab[$urandom_range(0, 4)];
      ra  = $urandom;
      rb  = (i % 3 == 0) ? ra : $urandom;
      applyStimulus(rop, rfn, ra, rb, waits);
      checkOutput("b2b_no_stall", waits, 0);
    end

    // Reset ten cycles into a multiply discards it.
    applyStimulus(2'b11, 6'b100000, $urandom, $urandom, waits);
    repeat (9) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    sbQueue.delete();
    sawValid = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_output", sawValid, 0);
    stepCycle();
    applyStimulus(2'b00, 6'b000000, 32'd9, 32'd10, waits);
    waitResult(lat, rdy);
    checkOutput("abort_add_latency", lat, 1);
    checkOutput("abort_add_result", result, 19);

    repeat (3) stepCycle();
    checkOutput("sb_drained", sbQueue.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, handshaked successor to the single-cycle ALU control path. It merges operation decode (ALUOp/func) with a registered execution stage.
- Adds an iterative multi-cycle multiply, which needs a state machine.
- Sits between decode and writeback in the multi-cycle/pipelined MIPS datapath. Uses valid/ready on both sides so stalls propagate.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 4.
- MUL_EN, 1: 1 enables MUL_FUNC; 0 makes MUL_FUNC illegal.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  unit accepts this cycle
- alu_op  in  2  00 add (lw/sw), 01 sub (beq), 10 slt (slti), 11 decode func
- func  in  6  one-hot: 000001 add, 000010 sub, 000100 and, 001000 or, 010000 slt, 100000 mul
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result
- zero  out  1  result == 0
- illegal  out  1  alu_op=11 with an unlisted func (or mul with MUL_EN=0)

Behaviour:
- Accept happens when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from registered state and out_ready.
- Reset values: out_valid=0, result=0, zero=0, illegal=0, state=IDLE, mul counter=0. in_ready=1 in the cycle after reset deasserts.
- Decoded operations (3-bit): NOTHING=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, MUL=6.
- Arithmetic: ADD/SUB are modulo 2^WIDTH with carry discarded.
- SLT: signed two's-complement compare; result = {(WIDTH-1) zeros, a<b}.
- MUL: low WIDTH bits of the unsigned product; signed and unsigned low halves are identical.
- Illegal: result=0, illegal=1, zero=1. It completes in the single-cycle path.
- States:
  - IDLE: on accept of a non-MUL op, register result/zero/illegal and set out_valid at the next edge (latency 1). Stay in IDLE.
  - IDLE -> MUL_RUN on accept of MUL. Latch a as the multiplicand and b as the multiplier, clear the accumulator, load count=WIDTH.
  - MUL_RUN: each cycle, if multiplier[0] then acc += multiplicand. Then shift multiplicand left 1, shift multiplier right 1, count-=1.
  - MUL_RUN -> IDLE at the edge where count reaches 0. That edge writes result=acc and sets out_valid.
  - MUL latency from accept edge to out_valid is WIDTH+1 cycles.
- Output hold: result/zero/illegal/out_valid are stable while out_valid && !out_ready.
- out_valid clears on an out_ready handshake unless a new op is accepted in the same cycle.
- Back-to-back single-cycle ops sustain 1 result per cycle when out_ready=1.
- Simultaneous out_ready handshake and new accept: the new result replaces the old at the next edge with out_valid held at 1.
- While in MUL_RUN, in_ready=0. A pending out_valid from an earlier op may still drain during MUL_RUN.
- Reset mid-MUL: state returns to IDLE and the partial product is discarded with no output produced. The same applies if out_valid is pending; the held result is discarded.
- in_valid with in_ready=0: inputs are ignored; the producer must hold them.
- Counter width: $clog2(WIDTH+1).

Decomposition:
- Package alu_pkg:
  - typedef enum logic[2:0] alu_op_e {NOTHING, ADD, SUB, AND, OR, SLT, MUL}
  - localparam func codes ADD_FUNC..MUL_FUNC
  - localparams for ALUOp encodings
  - typedef enum state_e {IDLE, MUL_RUN}
- Sub-module alu_decode: purely combinational (alu_op, func, MUL_EN) -> (alu_op_e, illegal).
- The top holds the datapath, FSM and output register.

Test Plan:
- Reset hold with in_valid=1, then release: out_valid=0, result=0, in_ready=1. The first accept (alu_op=00, a=5, b=7) gives result=12, zero=0 one cycle later.
- alu_op=11, func=000010, a=3, b=3 -> result=0, zero=1.
- alu_op=10, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1). Then a=1, b=0xFFFFFFFF -> result=0.
- MUL func=100000, a=0x0001_0003, b=0x0000_0005:
  - result=0x0005_000F, out_valid exactly 33 cycles after accept.
  - in_ready=0 throughout MUL_RUN.
- Backpressure: out_ready=0 for 4 cycles after an AND (a=0xF0F0, b=0xFF00): result holds at 0x0000_F000 and in_ready stays 0. Raising out_ready together with in_valid (OR, a=1, b=2) yields result=3 at the next edge with out_valid continuously 1.
- Illegal and abort:
  - func=000011 -> illegal=1, result=0.
  - MUL_EN=0 with func=100000 -> illegal=1.
  - rst asserted 10 cycles into a MUL -> no out_valid; the next ADD completes in 1 cycle.
